// File: rtl/serv_dbg_defs.sv
// Shared definitions for the SERV debug run-control sequencer.
// State encodings, default timing constants and the output decode.
package serv_dbg_defs;

    localparam int CNT_W = 10;

    localparam int unsigned DEF_RST_CYCLES = 4;
    localparam logic [CNT_W-1:0] DEF_HALT_TIMEOUT = 10'd1023;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_HALTING  = 3'd1,
        ST_HALTED   = 3'd2,
        ST_RESUMING = 3'd3,
        ST_STEP     = 3'd4,
        ST_RESET    = 3'd5
    } dbg_state_e;

    typedef struct packed {
        logic dbg_halt;
        logic dbg_reset;
        logic halted;
        logic running;
    } dbg_out_t;

    // Level outputs that depend only on the state being entered.
    function automatic dbg_out_t decode_outputs(dbg_state_e s);
        dbg_out_t o;
        o.dbg_halt  = (s == ST_HALTING) || (s == ST_HALTED);
        o.dbg_reset = (s == ST_RESET);
        o.halted    = (s == ST_HALTED) || (s == ST_RESUMING);
        o.running   = (s == ST_RUN) || (s == ST_STEP);
        return o;
    endfunction

endpackage

// File: rtl/serv_dbg_cnt.sv
// Loadable saturating up-counter with terminal-count flag.
// Shared between the reset pulse and the halt timeout.
module serv_dbg_cnt
    import serv_dbg_defs::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_term,
    output logic             o_tc
);

    logic [CNT_W-1:0] cnt;

    assign o_tc = (cnt >= i_term);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (i_load) begin
            cnt <= i_load_val;
        end else if (i_clr) begin
            cnt <= '0;
        end else if (i_en && !o_tc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serv_dbg_ctrl.sv
// Debug run-control sequencer: turns DM halt/resume/ndmreset requests
// into SERV halt/resume/reset handshakes and reports status back.
module serv_dbg_ctrl
    import serv_dbg_defs::*;
#(
    parameter int unsigned      RST_CYCLES   = DEF_RST_CYCLES,
    parameter logic [CNT_W-1:0] HALT_TIMEOUT = DEF_HALT_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_haltreq,
    input  logic i_resumereq,
    input  logic i_ndmreset,
    input  logic i_ackhavereset,
    input  logic i_clr_err,
    input  logic i_dbg_entry,
    input  logic i_dret_done,
    input  logic i_step,
    output logic o_dbg_halt,
    output logic o_dbg_reset,
    output logic o_dbg_resume,
    output logic o_halted,
    output logic o_running,
    output logic o_resumeack,
    output logic o_havereset,
    output logic o_halt_err
);

    localparam logic [CNT_W-1:0] RST_TERM = CNT_W'(RST_CYCLES);

    dbg_state_e state;
    dbg_state_e state_n;
    dbg_out_t   outs_n;

    logic resume_q;
    logic ndm_q;
    logic resume_rise;
    logic ndm_rise;

    logic             cnt_load;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt_term;

    logic err_set;
    logic resume_go;
    logic ack_go;

    assign resume_rise = i_resumereq && !resume_q;
    assign ndm_rise    = i_ndmreset && !ndm_q;

    // First cycle of a timed state counts as 1, so tc marks the last one.
    assign cnt_term = (state == ST_RESET) ? RST_TERM : HALT_TIMEOUT;

    serv_dbg_cnt u_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (cnt_load),
        .i_load_val (CNT_W'(1)),
        .i_clr      (cnt_clr),
        .i_en       (cnt_en),
        .i_term     (cnt_term),
        .o_tc       (cnt_tc)
    );

    always_comb begin
        state_n  = state;
        cnt_load = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        if (ndm_rise) begin
            state_n  = ST_RESET;
            cnt_load = 1'b1;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (i_dbg_entry) begin
                        state_n = ST_HALTED;
                    end else if (i_haltreq) begin
                        state_n  = ST_HALTING;
                        cnt_load = 1'b1;
                    end
                end
                ST_HALTING: begin
                    cnt_en = 1'b1;
                    if (i_dbg_entry) begin
                        state_n = ST_HALTED;
                        cnt_clr = 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (resume_rise && !i_haltreq) begin
                        state_n = ST_RESUMING;
                    end
                end
                ST_RESUMING: begin
                    if (i_dret_done) begin
                        state_n = i_step ? ST_STEP : ST_RUN;
                    end
                end
                ST_STEP: begin
                    if (i_dbg_entry) begin
                        state_n = ST_HALTED;
                    end
                end
                ST_RESET: begin
                    cnt_en = 1'b1;
                    if (cnt_tc) begin
                        state_n = i_haltreq ? ST_HALTED : ST_RUN;
                        cnt_clr = 1'b1;
                    end
                end
                default: begin
                    state_n = ST_RUN;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    assign outs_n    = decode_outputs(state_n);
    assign err_set   = (state == ST_HALTING) && cnt_tc;
    assign resume_go = (state == ST_HALTED) && (state_n == ST_RESUMING);
    assign ack_go    = (state == ST_RESUMING)
                    && ((state_n == ST_RUN) || (state_n == ST_STEP));

    // Sticky flags: a set event in the same cycle beats the clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_RUN;
            resume_q     <= 1'b0;
            ndm_q        <= 1'b0;
            o_dbg_halt   <= 1'b0;
            o_dbg_reset  <= 1'b0;
            o_dbg_resume <= 1'b0;
            o_halted     <= 1'b0;
            o_running    <= 1'b1;
            o_resumeack  <= 1'b0;
            o_havereset  <= 1'b1;
            o_halt_err   <= 1'b0;
        end else begin
            state        <= state_n;
            resume_q     <= i_resumereq;
            ndm_q        <= i_ndmreset;
            o_dbg_halt   <= outs_n.dbg_halt;
            o_dbg_reset  <= outs_n.dbg_reset;
            o_dbg_resume <= resume_go;
            o_halted     <= outs_n.halted;
            o_running    <= outs_n.running;
            o_resumeack  <= ack_go;
            o_havereset  <= outs_n.dbg_reset
                         || (o_havereset && !i_ackhavereset);
            o_halt_err   <= err_set || (o_halt_err && !i_clr_err);
        end
    end

endmodule

// File: doc/serv_dbg_ctrl.md
# serv_dbg_ctrl

Debug run-control sequencer for the SERV core. It sits between the debug-module register interface (DMI side) and the core's debug hooks: halt, debug reset, and the `dcsr.step` readback. It turns level halt, resume and non-debug-module reset (ndmreset) requests into the core's halt/resume/reset handshakes, tracks run/halt/step state, and reports status and sticky flags back to the debug module.

## Interface
Parameters:
- `RST_CYCLES`, default 4: cycles `o_dbg_reset` is held per ndmreset; valid range 1–15.
- `HALT_TIMEOUT`, default 1023: cycles allowed in HALTING before `o_halt_err` is set; width 10 bits.

Ports:
- `i_clk` in 1: clock. One clock domain.
- `i_rst` in 1: reset, synchronous and active-high.
- `i_haltreq` in 1: DM halt request (level).
- `i_resumereq` in 1: DM resume request (level, sampled on rising edge).
- `i_ndmreset` in 1: DM core-reset request (level, sampled on rising edge).
- `i_ackhavereset` in 1: clears `o_havereset`.
- `i_clr_err` in 1: clears `o_halt_err`.
- `i_dbg_entry` in 1: core strobe, debug mode entered (halt, ebreak or step).
- `i_dret_done` in 1: core strobe, dret retired and debug mode left.
- `i_step` in 1: `dcsr.step` from the CSR block.
- `o_dbg_halt` out 1: drives core `i_dbg_halt`.
- `o_dbg_reset` out 1: drives core `i_dbg_reset`.
- `o_dbg_resume` out 1: one-cycle strobe; the core executes dret.
- `o_halted` out 1: core is halted in debug mode.
- `o_running` out 1: core is running (RUN or STEP).
- `o_resumeack` out 1: one-cycle strobe, resume completed.
- `o_havereset` out 1: sticky; core has been reset.
- `o_halt_err` out 1: sticky; halt timed out.

## Operation
- States: RUN, HALTING, HALTED, RESUMING, STEP, RESET.
- Reset (`i_rst`):
  - State goes to RUN; counters clear.
  - `o_havereset` = 1; every other output = 0, except `o_running` = 1.
- RUN:
  - `i_haltreq` → HALTING.
  - `i_dbg_entry` (ebreak) → HALTED directly.
  - `i_resumereq` is ignored.
- HALTING:
  - `o_dbg_halt` = 1; the timeout counter runs.
  - `i_dbg_entry` → HALTED.
  - If the counter reaches `HALT_TIMEOUT`, `o_halt_err` is set and the state stays HALTING.
- HALTED:
  - `o_dbg_halt` = 1 and `o_halted` = 1.
  - A `i_resumereq` rising edge with `i_haltreq` low → RESUMING and emits `o_dbg_resume`.
  - If `i_haltreq` is high, the resume edge is dropped.
- RESUMING:
  - `o_dbg_halt` = 0 and `o_halted` = 1.
  - `i_dret_done` → STEP if `i_step` = 1, else RUN.
  - Both transitions pulse `o_resumeack` and clear `o_halted`.
- STEP:
  - `o_dbg_halt` = 0; the core executes one instruction and re-enters debug by itself.
  - `i_dbg_entry` → HALTED.
  - `i_haltreq` is ignored.
- RESET:
  - Entered from any state on an `i_ndmreset` rising edge.
  - `o_dbg_reset` = 1 for exactly `RST_CYCLES` cycles.
  - `o_havereset` is set.
  - Exit to HALTED (halt-on-reset) if `i_haltreq` = 1 on the final cycle, else RUN.
  - Exiting straight to HALTED asserts `o_dbg_halt` with no entry handshake.
- Priority, highest first: ndmreset, then `i_dbg_entry`, then `i_haltreq`, then `i_resumereq`.
- `i_ackhavereset` together with a set event in the same cycle: set wins. The same rule applies to `i_clr_err`.
- Strobes `i_dbg_entry` / `i_dret_done` arriving in a state that does not expect them are ignored; RUN handles `i_dbg_entry` as ebreak, as above.
- `o_running` = 1 in RUN and STEP only.

## Timing
- All outputs are registered; every transition takes effect on the cycle after the causing input.
- Latencies:
  - `i_haltreq` at cycle N in RUN → `o_dbg_halt` = 1 at N+1.
  - `i_dbg_entry` at M → `o_halted` = 1 at M+1.
  - Resume edge at N → `o_dbg_resume` high for cycle N+1 only, and `o_dbg_halt` = 0 at N+1.
  - `i_dret_done` at K → `o_resumeack` high for K+1 only.
  - ndmreset edge at N → `o_dbg_reset` high for cycles N+1 to N+`RST_CYCLES`; the exit state is valid at N+`RST_CYCLES`+1.
- Edge detectors on `i_resumereq` and `i_ndmreset` are registered and reset to 0. A request held high through `i_rst` therefore triggers an edge on the first cycle after reset.
- The halt timeout counter saturates and clears on leaving HALTING.
- ndmreset arriving mid-RESET restarts the count.
- `i_rst` mid-operation aborts any state immediately.

## Structure
- Shared header/package `serv_dbg_defs`:
  - 3-bit state encodings (RUN=0, HALTING=1, HALTED=2, RESUMING=3, STEP=4, RESET=5).
  - Default `RST_CYCLES` / `HALT_TIMEOUT` constants.
- Sub-module `serv_dbg_cnt`: a loadable 10-bit up-counter with terminal-count flag. It is reused for both the reset-pulse length and the halt timeout, since the two are never active together.
- The FSM, edge detectors and sticky flags live in the top module.

## Test plan
- After `i_rst`, `i_haltreq` pulses at cycle 10 and `i_dbg_entry` at cycle 14 → `o_dbg_halt` = 1 from cycle 11, `o_halted` = 1 from cycle 15, `o_running` = 0.
- HALTED with `i_step` = 0: resume edge at cycle 20, `i_dret_done` at 25 → `o_dbg_resume` only at 21, `o_resumeack` only at 26, state RUN.
- Same resume with `i_step` = 1, then `i_dbg_entry` at 30 → STEP from 26, HALTED at 31, `o_halted` = 1.
- `i_ndmreset` edge at cycle 5 with `i_haltreq` = 1 and `RST_CYCLES` = 4 → `o_dbg_reset` at cycles 6–9, `o_havereset` = 1, `o_halted` = 1 at 10. `i_ackhavereset` at 12 → `o_havereset` = 0 at 13.
- HALTING with no `i_dbg_entry` and `HALT_TIMEOUT` = 8 → `o_halt_err` = 1 after 8 cycles, then a late `i_dbg_entry` → HALTED. `i_clr_err` → 0.
- HALTED with resume edge and `i_haltreq` both high → no `o_dbg_resume`, state remains HALTED.
